// File: rtl/moore_sym_tx.sv
// moore_sym_tx: serializes DATA_W-bit words into 2-bit level-signalling symbols, one bit per clock.
// Latency: a word accepted at edge T puts bit i on sym_out in cycle T+1+i; done pulses in cycle T+DATA_W+1.
// Backpressure: in_ready is high only when idle or on the last symbol of a frame, so back-to-back frames leave no gap.
// Ports: clk/reset (sync, active-high); in_data/in_valid/in_ready word handshake; sync_req returns an idle line to 0;
//        sym_out registered symbol; line_level mirrored decoder level; busy while framing; done end-of-frame pulse.
module moore_sym_tx #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sync_req,
    output logic [1:0]        sym_out,
    output logic              line_level,
    output logic              busy,
    output logic              done
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sym_q, sym_d;
    logic              level_q, level_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              done_q, done_d;

    logic              last_sym;
    logic              accept;
    logic              nxt_bit;

    // Symbol that moves the decoder from level l to bit b; 11 is never used.
    function automatic logic [1:0] encode(input logic b, input logic l);
        if (b == l) begin
            return 2'b00;
        end else if (b) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

    // The bit to send next always sits at the outgoing end of the word.
    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign last_sym = (state_q == SEND) && (cnt_q == LAST_CNT);
    assign in_ready = !reset && ((state_q == IDLE) || last_sym);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sym_d   = 2'b00;
        level_d = level_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        nxt_bit = 1'b0;
        // The last symbol of a frame is on the line now, so done follows next cycle
        // even when a new frame is being loaded on the same edge.
        done_d  = last_sym;

        if (accept) begin
            // The first bit is encoded straight from in_data so it appears the next cycle.
            nxt_bit = head_bit(in_data);
            state_d = SEND;
            sym_d   = encode(nxt_bit, level_q);
            level_d = nxt_bit;
            shift_d = advance(in_data);
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sync_req && level_q) begin
                        sym_d   = 2'b01;
                        level_d = 1'b0;
                    end
                end
                SEND: begin
                    if (last_sym) begin
                        state_d = IDLE;
                    end else begin
                        nxt_bit = head_bit(shift_q);
                        sym_d   = encode(nxt_bit, level_q);
                        level_d = nxt_bit;
                        shift_d = advance(shift_q);
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Reset happens on the same edge as the decoder's reset, keeping the level mirror aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sym_q   <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    assign sym_out    = sym_q;
    assign line_level = level_q;
    assign busy       = (state_q == SEND);
    assign done       = done_q;

endmodule
